// File: rtl/ipm_sync_pkg.sv
// Shared types, port indices, flit field layout and XY routing for the router input port.
package ipm_sync_pkg;

  // Flit type carried in the two most significant bits of every flit
  typedef enum logic [1:0] {
    FLIT_BODY     = 2'b00,
    FLIT_HEAD     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_e;

  // Input port controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_FWD  = 2'b10,
    ST_DROP = 2'b11
  } state_e;

  // Global port indices; local ports follow at PORTS_G + l
  localparam int unsigned PORT_N = 0;
  localparam int unsigned PORT_E = 1;
  localparam int unsigned PORT_S = 2;
  localparam int unsigned PORT_W = 3;

  // Field layout measured from the flit MSB: type, then destX, destY, local index
  localparam int unsigned TYPE_W    = 2;
  localparam int unsigned DESTX_OFS = TYPE_W;

  // Width of the local port index field (at least one bit)
  function automatic int unsigned lsel_width(input int unsigned ports_l);
    return (ports_l > 1) ? $clog2(ports_l) : 1;
  endfunction

  // Dimension-ordered routing: resolve X first, then Y, then pick the local port
  function automatic int unsigned route_xy(input int unsigned dest_x,
                                           input int unsigned dest_y,
                                           input int unsigned lidx,
                                           input int unsigned loc_x,
                                           input int unsigned loc_y,
                                           input int unsigned ports_g);
    if (dest_x > loc_x)      return PORT_E;
    else if (dest_x < loc_x) return PORT_W;
    else if (dest_y > loc_y) return PORT_N;
    else if (dest_y < loc_y) return PORT_S;
    else                     return ports_g + lidx;
  endfunction

endpackage

// File: rtl/ipm_sync_fifo.sv
// Flit buffer: DEPTH-entry circular FIFO with registered count, head data always visible.
module ipm_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  // Requests are qualified here so the caller never over- or under-runs the buffer
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_data  = r_mem[r_rd];

  // Storage and pointers; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ipm_sync.sv
// NoC router input port: buffers flits, XY-routes head flits, requests an output and
// forwards the packet wormhole-style once granted; illegal packets are dropped with err_o.
module ipm_sync
  import ipm_sync_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PORTS_G   = 4,
  parameter int unsigned PORTS_L   = 1,
  parameter int unsigned LOCALPORT = 1,
  parameter int unsigned POS       = 0,
  parameter int unsigned LocationX = 2,
  parameter int unsigned LocationY = 2,
  parameter int unsigned COORD_W   = 4,
  parameter int unsigned NOUT      = PORTS_G + PORTS_L - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             up_ready_o,
  output logic [NOUT-1:0]  dw_req_o,
  input  logic [NOUT-1:0]  dw_grant_i,
  output logic [NOUT-1:0]  dw_valid_o,
  output logic [WIDTH-1:0] dw_data_o,
  input  logic [NOUT-1:0]  dw_ready_i,
  output logic             err_o
);

  localparam int unsigned LSEL_W = lsel_width(PORTS_L);
  localparam int unsigned SEL_W  = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int unsigned OWN    = (LOCALPORT != 0) ? (PORTS_G + POS) : POS;
  localparam int unsigned X_MSB  = WIDTH - 1 - DESTX_OFS;
  localparam int unsigned Y_MSB  = X_MSB - COORD_W;
  localparam int unsigned L_MSB  = Y_MSB - COORD_W;

  state_e           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [NOUT-1:0]  r_req;
  logic             r_err;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;
  flit_type_e       w_type;
  logic             w_is_head;
  logic             w_is_last;
  logic [COORD_W-1:0] w_dest_x;
  logic [COORD_W-1:0] w_dest_y;
  logic [LSEL_W-1:0]  w_lidx;
  int unsigned      w_route;
  int unsigned      w_out;
  logic             w_illegal;

  // Upstream acceptance never depends on a same-cycle pop
  assign up_ready_o = ~w_full;
  assign w_push     = up_valid_i & ~w_full;

  ipm_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (up_data_i),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Head-flit field extraction
  assign w_type    = flit_type_e'(w_head[WIDTH-1 -: TYPE_W]);
  assign w_is_head = (w_type == FLIT_HEAD) || (w_type == FLIT_HEADTAIL);
  assign w_is_last = (w_type == FLIT_TAIL) || (w_type == FLIT_HEADTAIL);
  assign w_dest_x  = w_head[X_MSB -: COORD_W];
  assign w_dest_y  = w_head[Y_MSB -: COORD_W];
  assign w_lidx    = w_head[L_MSB -: LSEL_W];

  // Route the head flit and compress the absolute port onto the NOUT outputs (own port removed)
  always_comb begin
    w_route   = route_xy(32'(w_dest_x), 32'(w_dest_y), 32'(w_lidx),
                         LocationX, LocationY, PORTS_G);
    w_out     = (w_route < OWN) ? w_route : (w_route - 32'd1);
    w_illegal = (w_route == OWN) || (32'(w_lidx) >= PORTS_L);
  end

  // Pop decision: orphan flits in IDLE, accepted flits in FWD, everything in DROP
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE: w_pop = ~w_empty & ~w_is_head;
      ST_FWD:  w_pop = ~w_empty & dw_ready_i[r_sel];
      ST_DROP: w_pop = ~w_empty;
      default: w_pop = 1'b0;
    endcase
  end

  // Packet controller: route/request/forward/drop with registered request and error outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_req   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            if (!w_is_head) begin
              r_err <= 1'b1;
            end else if (w_illegal) begin
              r_err   <= 1'b1;
              r_state <= ST_DROP;
            end else begin
              r_sel   <= SEL_W'(w_out);
              r_req   <= NOUT'(1) << w_out;
              r_state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dw_grant_i[r_sel]) r_state <= ST_FWD;
        end
        ST_FWD: begin
          if (w_pop && w_is_last) begin
            r_req   <= '0;
            r_state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (w_pop && w_is_last) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Valid follows the held request while a flit is buffered in FWD
  assign dw_valid_o = ((r_state == ST_FWD) && !w_empty) ? r_req : '0;
  assign dw_req_o   = r_req;
  assign dw_data_o  = w_head;
  assign err_o      = r_err;

endmodule

// File: tb/tb_ipm_sync.sv
// Scoreboard bench for ipm_sync: three instances (W global, local 0, N global) share stimulus.
module tb_ipm_sync;

  typedef struct packed {
    logic [4:0]  port;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        up_valid;
  logic [31:0] up_data;
  logic [4:0]  grant;
  logic [4:0]  rdy;
  logic [1:0]  dsel;

  logic [2:0]  uv;
  logic [2:0]  ready_all;
  logic [2:0]  err_all;
  logic [4:0]  req_all   [3];
  logic [4:0]  valid_all [3];
  logic [31:0] data_all  [3];

  logic [4:0]  m_req;
  logic [4:0]  m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic        m_err;

  exp_t        sb [$];
  exp_t        m_exp;
  int          checks;
  int          errors;
  int          err_cnt;
  int          xfer_cnt;
  logic [4:0]  req_or;
  logic [4:0]  valid_or;

  assign uv[0] = up_valid && (dsel == 2'd0);
  assign uv[1] = up_valid && (dsel == 2'd1);
  assign uv[2] = up_valid && (dsel == 2'd2);

  // Input W of router (2,2)
  ipm_sync #(.PORTS_L(2), .LOCALPORT(0), .POS(3)) u_dut_w (
    .clk(clk), .reset(reset), .up_valid_i(uv[0]), .up_data_i(up_data),
    .up_ready_o(ready_all[0]), .dw_req_o(req_all[0]), .dw_grant_i(grant),
    .dw_valid_o(valid_all[0]), .dw_data_o(data_all[0]), .dw_ready_i(rdy),
    .err_o(err_all[0]));

  // Local input 0 of router (2,2)
  ipm_sync #(.PORTS_L(2), .LOCALPORT(1), .POS(0)) u_dut_l (
    .clk(clk), .reset(reset), .up_valid_i(uv[1]), .up_data_i(up_data),
    .up_ready_o(ready_all[1]), .dw_req_o(req_all[1]), .dw_grant_i(grant),
    .dw_valid_o(valid_all[1]), .dw_data_o(data_all[1]), .dw_ready_i(rdy),
    .err_o(err_all[1]));

  // Input N of router (2,2)
  ipm_sync #(.PORTS_L(2), .LOCALPORT(0), .POS(0)) u_dut_n (
    .clk(clk), .reset(reset), .up_valid_i(uv[2]), .up_data_i(up_data),
    .up_ready_o(ready_all[2]), .dw_req_o(req_all[2]), .dw_grant_i(grant),
    .dw_valid_o(valid_all[2]), .dw_data_o(data_all[2]), .dw_ready_i(rdy),
    .err_o(err_all[2]));

  always_comb begin
    m_req   = req_all[dsel];
    m_valid = valid_all[dsel];
    m_data  = data_all[dsel];
    m_ready = ready_all[dsel];
    m_err   = err_all[dsel];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are stable at the falling edge; a valid&ready here transfers at the next rise
  always @(negedge clk) begin
    if (!reset) begin
      req_or   = req_or | m_req;
      valid_or = valid_or | m_valid;
      if (m_err) err_cnt++;
      if ((m_valid & rdy) != 5'b0) begin
        xfer_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL xfer_unexpected: port=%b data=%h, none expected", m_valid, m_data);
        end else begin
          m_exp = sb.pop_front();
          if (m_valid !== m_exp.port || m_data !== m_exp.data) begin
            errors++;
            $display("FAIL xfer: port=%b data=%h, want port=%b data=%h",
                     m_valid, m_data, m_exp.port, m_exp.data);
          end
        end
      end
    end
  end

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] dx,
                                     input logic [3:0] dy, input logic l,
                                     input logic [20:0] pl);
    return {t, dx, dy, l, pl};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds a flit on the upstream bus until accepted; returns at accept edge + 1
  task automatic push_flit(input logic [31:0] f, output bit ok);
    ok       = 1'b0;
    up_data  = f;
    up_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (m_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    up_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; up_valid = 1'b0; up_data = '0; grant = '0; rdy = '0; dsel = 2'd0;
    req_or = '0; valid_or = '0;
    tick(3);
    checks++; if (m_req !== 5'b0)   begin errors++; $display("FAIL rst_req: got %b want 00000", m_req); end
    checks++; if (m_valid !== 5'b0) begin errors++; $display("FAIL rst_valid: got %b want 00000", m_valid); end
    checks++; if (m_err !== 1'b0)   begin errors++; $display("FAIL rst_err: got %b want 0", m_err); end
    reset = 1'b0;
    tick(1);
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", m_ready); end
  endtask

  // Head+tail to (3,2) from input W: east, output 1, REQ one edge after push, FWD the next
  task automatic test_single_flit;
    logic [31:0] f; bit ok; int e0;
    dsel = 2'd0; grant = '1; rdy = '1; e0 = err_cnt;
    f = mk(2'b11, 4'd3, 4'd2, 1'b0, 21'h0A5A5);
    sb.push_back('{port: 5'b00010, data: f});
    push_flit(f, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_push: got timeout want accept"); end
    checks++; if (m_req !== 5'b0) begin errors++; $display("FAIL t1_req_c0: got %b want 00000", m_req); end
    tick(1);
    checks++; if (m_req !== 5'b00010) begin errors++; $display("FAIL t1_req_c1: got %b want 00010", m_req); end
    checks++; if (m_valid !== 5'b0) begin errors++; $display("FAIL t1_valid_c1: got %b want 00000", m_valid); end
    tick(1);
    checks++; if (m_valid !== 5'b00010 || m_data !== f) begin errors++; $display("FAIL t1_fwd_c2: got %b/%h want 00010/%h", m_valid, m_data, f); end
    tick(1);
    checks++; if (m_req !== 5'b0 || m_valid !== 5'b0) begin errors++; $display("FAIL t1_done: got req %b valid %b want 0/0", m_req, m_valid); end
    checks++; if (err_cnt - e0 != 0 || sb.size() != 0) begin errors++; $display("FAIL t1_err_sb: got err %0d left %0d want 0/0", err_cnt - e0, sb.size()); end
  endtask

  // 3-flit packet from local 0 to local 1 (absolute 5 -> output 4) with toggling ready
  task automatic test_wormhole;
    logic [31:0] f [3]; bit ok, ok_all; int x0;
    dsel = 2'd1; grant = '1; rdy = '1; x0 = xfer_cnt; req_or = '0; ok_all = 1'b1;
    f[0] = mk(2'b01, 4'd2, 4'd2, 1'b1, 21'h00001);
    f[1] = mk(2'b00, 4'd9, 4'd1, 1'b0, 21'h1BEEF);
    f[2] = mk(2'b10, 4'd0, 4'd7, 1'b1, 21'h0CAFE);
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{port: 5'b10000, data: f[i]});
      push_flit(f[i], ok);
      ok_all &= ok;
    end
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      rdy = ~rdy;
      tick(1);
    end
    rdy = '1;
    checks++; if (!ok_all || sb.size() != 0) begin errors++; $display("FAIL t2_drain: got ok %b left %0d want 1/0", ok_all, sb.size()); end
    checks++; if (xfer_cnt - x0 != 3) begin errors++; $display("FAIL t2_count: got %0d want 3", xfer_cnt - x0); end
    checks++; if (req_or !== 5'b10000) begin errors++; $display("FAIL t2_req_seen: got %b want 10000", req_or); end
    checks++; if (m_req !== 5'b0) begin errors++; $display("FAIL t2_req_drop: got %b want 00000", m_req); end
  endtask

  // Back-pressure: no grant, FIFO fills after 4 flits, drains once granted
  task automatic test_full;
    logic [31:0] f [5]; bit ok, ok_all; int x0;
    dsel = 2'd0; grant = '0; rdy = '1; x0 = xfer_cnt; valid_or = '0; ok_all = 1'b1;
    f[0] = mk(2'b01, 4'd3, 4'd2, 1'b0, 21'h00010);
    for (int i = 1; i < 4; i++) f[i] = mk(2'b00, 4'(i), 4'd0, 1'b0, 21'(32'h100 + i));
    f[4] = mk(2'b10, 4'd0, 4'd0, 1'b0, 21'h00444);
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{port: 5'b00010, data: f[i]});
      push_flit(f[i], ok);
      ok_all &= ok;
    end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL t3_full: got ready %b want 0", m_ready); end
    checks++; if (m_req !== 5'b00010) begin errors++; $display("FAIL t3_req_wait: got %b want 00010", m_req); end
    up_data = f[4]; up_valid = 1'b1;
    tick(3);
    checks++; if (m_ready !== 1'b0 || valid_or !== 5'b0) begin errors++; $display("FAIL t3_hold: got ready %b valid %b want 0/00000", m_ready, valid_or); end
    sb.push_back('{port: 5'b00010, data: f[4]});
    grant = '1;
    push_flit(f[4], ok);
    ok_all &= ok;
    wait_drain(ok);
    ok_all &= ok;
    checks++; if (!ok_all) begin errors++; $display("FAIL t3_drain: got timeout want drained"); end
    checks++; if (m_ready !== 1'b1 || m_req !== 5'b0) begin errors++; $display("FAIL t3_after: got ready %b req %b want 1/00000", m_ready, m_req); end
    checks++; if (xfer_cnt - x0 != 5) begin errors++; $display("FAIL t3_count: got %0d want 5", xfer_cnt - x0); end
  endtask

  // Input N: packet to (2,3) turns back north -> dropped; then a west-bound packet (output 2)
  task automatic test_drop_own;
    logic [31:0] f; bit ok, ok_all; int e0;
    dsel = 2'd2; grant = '1; rdy = '1; e0 = err_cnt; req_or = '0; valid_or = '0; ok_all = 1'b1;
    push_flit(mk(2'b01, 4'd2, 4'd3, 1'b0, 21'h00D01), ok); ok_all &= ok;
    push_flit(mk(2'b00, 4'd1, 4'd1, 1'b0, 21'h00D02), ok); ok_all &= ok;
    push_flit(mk(2'b10, 4'd1, 4'd1, 1'b0, 21'h00D03), ok); ok_all &= ok;
    tick(8);
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL t4_err: got %0d pulses want 1", err_cnt - e0); end
    checks++; if (req_or !== 5'b0 || valid_or !== 5'b0) begin errors++; $display("FAIL t4_quiet: got req %b valid %b want 0/0", req_or, valid_or); end
    f = mk(2'b11, 4'd1, 4'd2, 1'b0, 21'h00777);
    sb.push_back('{port: 5'b00100, data: f});
    push_flit(f, ok); ok_all &= ok;
    wait_drain(ok); ok_all &= ok;
    checks++; if (!ok_all) begin errors++; $display("FAIL t4_drain: got timeout want drained"); end
    checks++; if (req_or !== 5'b00100 || err_cnt - e0 != 1) begin errors++; $display("FAIL t4_next: got req %b err %0d want 00100/1", req_or, err_cnt - e0); end
  endtask

  // Body then tail with no head: two orphan error pulses, no request
  task automatic test_orphan;
    bit ok, ok_all; int e0;
    dsel = 2'd0; grant = '1; rdy = '1; e0 = err_cnt; req_or = '0; valid_or = '0; ok_all = 1'b1;
    push_flit(mk(2'b00, 4'd3, 4'd2, 1'b0, 21'h00B0D), ok); ok_all &= ok;
    push_flit(mk(2'b10, 4'd3, 4'd2, 1'b0, 21'h00BAD), ok); ok_all &= ok;
    tick(6);
    checks++; if (!ok_all || err_cnt - e0 != 2) begin errors++; $display("FAIL t5_err: got ok %b pulses %0d want 1/2", ok_all, err_cnt - e0); end
    checks++; if (req_or !== 5'b0 || valid_or !== 5'b0 || m_ready !== 1'b1) begin errors++; $display("FAIL t5_quiet: got req %b valid %b ready %b want 0/0/1", req_or, valid_or, m_ready); end
  endtask

  // Reset after the second of four flits; then a south-bound packet (output 2)
  task automatic test_reset_mid;
    logic [31:0] f; bit ok, ok_all; int x0, e0;
    dsel = 2'd0; grant = '1; rdy = '1; x0 = xfer_cnt; ok_all = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f = mk((i == 0) ? 2'b01 : ((i == 3) ? 2'b10 : 2'b00), 4'd3, 4'd2, 1'b0, 21'(32'h600 + i));
      sb.push_back('{port: 5'b00010, data: f});
      push_flit(f, ok); ok_all &= ok;
    end
    for (int i = 0; i < 20; i++) begin
      if (xfer_cnt - x0 >= 2) break;
      tick(1);
    end
    reset = 1'b1;
    sb.delete();
    #1;
    checks++; if (xfer_cnt - x0 != 2) begin errors++; $display("FAIL t6_before: got %0d flits want 2", xfer_cnt - x0); end
    checks++; if (m_req !== 5'b0 || m_valid !== 5'b0 || m_err !== 1'b0) begin errors++; $display("FAIL t6_cleared: got req %b valid %b err %b want 0/0/0", m_req, m_valid, m_err); end
    tick(2);
    reset = 1'b0; e0 = err_cnt; req_or = '0;
    tick(4);
    checks++; if (err_cnt - e0 != 0 || req_or !== 5'b0 || m_ready !== 1'b1) begin errors++; $display("FAIL t6_empty: got err %0d req %b ready %b want 0/00000/1", err_cnt - e0, req_or, m_ready); end
    f = mk(2'b11, 4'd2, 4'd1, 1'b0, 21'h00515);
    sb.push_back('{port: 5'b00100, data: f});
    push_flit(f, ok); ok_all &= ok;
    wait_drain(ok); ok_all &= ok;
    checks++; if (!ok_all || req_or !== 5'b00100) begin errors++; $display("FAIL t6_next: got ok %b req %b want 1/00100", ok_all, req_or); end
  endtask

  initial begin
    checks = 0; errors = 0; err_cnt = 0; xfer_cnt = 0;
    test_reset();
    test_single_flit();
    test_wormhole();
    test_full();
    test_drop_own();
    test_orphan();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
